multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of the program counter; legal range 6..12.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  begin execution from PC 0; sampled only in IDLE.
REQ-005 i_instr  input  13  instruction word from instruction memory.
REQ-006 i_instrValid  input  1  i_instr is valid this cycle.
REQ-007 i_dataA  input  13  register-file port A read data.
REQ-008 o_pc  output  PC_WIDTH  instruction fetch address.
REQ-009 o_instrReq  output  1  fetch request; asserted only in FETCH.
REQ-010 o_memRead, o_memWrite  output  1 each  register-file read and write enables.
REQ-011 o_address1, o_address2, o_destReg  output  3 each  register-file read A, read B and write addresses.
REQ-012 o_aluOp  output  4  ALU operation; equals the decoded opcode.
REQ-013 o_aluSrcImm  output  1  ALU operand B comes from o_imm, not port B.
REQ-014 o_imm  output  13  zero-extended immediate.
REQ-015 o_busy, o_halt, o_illegal  output  1 each  running, halted, halted on an illegal instruction.

Function
REQ-016 Instruction fields: opcode [12:9], rd [8:6], rs [5:3], rt [2:0].
REQ-017 Opcodes: 0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT (rs only), 0111 SLL, 1000 SRL, 1001 ADDI (imm = rt), 1010 MOV (rs only), 1011 BEQZ, 1110 JMP, 1111 HALT; 1100 and 1101 are illegal.
REQ-018 States: IDLE, FETCH, DECODE, READ, EXEC, WB, HALT.
REQ-019 IDLE to FETCH on i_start = 1, with o_pc = 0.
REQ-020 FETCH: o_instrReq = 1 and o_pc held stable until i_instrValid = 1; the instruction is then latched and the next state is DECODE.
REQ-021 DECODE lasts one cycle. NOP: FETCH, pc+1. JMP: FETCH, pc = instr[7:0] truncated or zero-extended to PC_WIDTH. HALT: HALT state. Illegal: HALT state with o_illegal = 1. All other opcodes: READ.
REQ-022 Illegal also covers any register field used by the opcode equal to 3'b111: rd, rs and rt for ALU ops; rd and rs for NOT, MOV and ADDI; rd for BEQZ.
REQ-023 READ lasts one cycle: o_memRead = 1, o_address1 = rs (rd for BEQZ), o_address2 = rt; the register file presents data in the following cycle.
REQ-024 EXEC lasts one cycle: o_aluOp, o_aluSrcImm and o_imm valid.
REQ-025 BEQZ in EXEC: if i_dataA == 0, pc = {0, instr[5:0]}, else pc+1; next state FETCH, no WB.
REQ-026 WB lasts one cycle: o_memWrite = 1, o_destReg = rd, pc+1, then FETCH.
REQ-027 Latency is FETCH + 4 cycles for ALU ops, FETCH + 3 for BEQZ, and FETCH + 1 for NOP and JMP.
REQ-028 o_memRead and o_memWrite are never asserted in the same cycle; both are 0 outside READ and WB.
REQ-029 pc+1 wraps from 2^PC_WIDTH-1 to 0.
REQ-030 o_busy = 1 in every state except IDLE and HALT.
REQ-031 i_start is ignored outside IDLE.
REQ-032 HALT is terminal: o_halt = 1 and the block stays there until reset.
REQ-033 Address, aluOp and imm outputs hold their last values outside READ, EXEC and WB.

Reset
REQ-034 reset = 1 at a clock edge forces state IDLE, pc = 0 and every output to 0, overriding any other event that cycle.
REQ-035 Reset mid-operation (including mid-FETCH wait or in WB) aborts the instruction with no o_memWrite pulse in the following cycle.

Verification
REQ-036 ADD r3,r1,r2 (13'h02CA), valid on the first FETCH cycle -> memRead in cycle 3 with addr1=1 and addr2=2; memWrite in cycle 5 with destReg=3 and aluOp=1; pc=1.
REQ-037 BEQZ r2 to 6'd20 with i_dataA=0 -> next o_pc=20, no memWrite; same with i_dataA=5 -> o_pc=pc+1.
REQ-038 Opcode 1100, or ADD with rd=7 -> HALT with o_halt=1 and o_illegal=1; a later i_start has no effect.
REQ-039 i_instrValid delayed 5 cycles -> o_pc stable and o_instrReq high throughout, no other enables asserted.
REQ-040 JMP to 8'hFF then NOP -> o_pc=255, then o_pc=0 (wrap).
REQ-041 reset asserted during WB -> next cycle IDLE with all outputs 0; i_start restarts fetching at pc 0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Fetch, register-file and status signals between the multicycle controller and its environment.
`timescale 1ns/1ps
interface multicycle_controller_if #(
    parameter int PC_WIDTH = 8
);
    logic                i_start;
    logic [12:0]         i_instr;
    logic                i_instrValid;
    logic [12:0]         i_dataA;
    logic [PC_WIDTH-1:0] o_pc;
    logic                o_instrReq;
    logic                o_memRead;
    logic                o_memWrite;
    logic [2:0]          o_address1;
    logic [2:0]          o_address2;
    logic [2:0]          o_destReg;
    logic [3:0]          o_aluOp;
    logic                o_aluSrcImm;
    logic [12:0]         o_imm;
    logic                o_busy;
    logic                o_halt;
    logic                o_illegal;

    modport master (
        input  i_start, i_instr, i_instrValid, i_dataA,
        output o_pc, o_instrReq, o_memRead, o_memWrite,
        output o_address1, o_address2, o_destReg,
        output o_aluOp, o_aluSrcImm, o_imm,
        output o_busy, o_halt, o_illegal
    );

    modport slave (
        output i_start, i_instr, i_instrValid, i_dataA,
        input  o_pc, o_instrReq, o_memRead, o_memWrite,
        input  o_address1, o_address2, o_destReg,
        input  o_aluOp, o_aluSrcImm, o_imm,
        input  o_busy, o_halt, o_illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH, DECODE, READ, EXEC, WB over a 13-bit ISA,
// driving fetch requests, register-file enables and ALU controls.
`timescale 1ns/1ps
module multicycle_controller #(
    parameter int PC_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_MOV  = 4'b1010;
    localparam logic [3:0] OP_BEQZ = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [12:0]         instr_q, instr_d;
    logic [2:0]          addr1_q, addr1_d;
    logic [2:0]          addr2_q, addr2_d;
    logic [2:0]          dest_q, dest_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                src_imm_q, src_imm_d;
    logic [12:0]         imm_q, imm_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          opcode;
    logic [2:0]          rd_f, rs_f, rt_f;
    logic                uses_rd, uses_rs, uses_rt, bad_opcode, is_illegal;
    logic [PC_WIDTH-1:0] pc_inc, jump_pc, branch_pc;

    assign opcode = instr_q[12:9];
    assign rd_f   = instr_q[8:6];
    assign rs_f   = instr_q[5:3];
    assign rt_f   = instr_q[2:0];

    // Register 7 is reserved, so any field the opcode actually reads or writes may not name it.
    always_comb begin
        uses_rd    = 1'b0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        bad_opcode = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                uses_rd = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_NOT, OP_MOV, OP_ADDI: begin
                uses_rd = 1'b1;
                uses_rs = 1'b1;
            end
            OP_BEQZ:                 uses_rd = 1'b1;
            OP_NOP, OP_JMP, OP_HALT: bad_opcode = 1'b0;
            default:                 bad_opcode = 1'b1;
        endcase
        is_illegal = bad_opcode
                   | (uses_rd & (rd_f == 3'b111))
                   | (uses_rs & (rs_f == 3'b111))
                   | (uses_rt & (rt_f == 3'b111));
    end

    // Jump and branch targets are zero-extended or truncated to whatever PC_WIDTH is.
    always_comb begin
        pc_inc    = pc_q + PC_WIDTH'(1);
        jump_pc   = '0;
        branch_pc = '0;
        for (int i = 0; i < PC_WIDTH; i++) begin
            if (i < 8) jump_pc[i] = instr_q[i];
            if (i < 6) branch_pc[i] = instr_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        dest_d    = dest_q;
        alu_op_d  = alu_op_q;
        src_imm_d = src_imm_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (bus.i_instrValid) begin
                    instr_d = bus.i_instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    case (opcode)
                        OP_NOP: begin
                            state_d = S_FETCH;
                            pc_d    = pc_inc;
                        end
                        OP_JMP: begin
                            state_d = S_FETCH;
                            pc_d    = jump_pc;
                        end
                        OP_HALT: state_d = S_HALT;
                        default: begin
                            // Operand fields are captured here and then held until the next register-reading instruction.
                            state_d   = S_READ;
                            addr1_d   = (opcode == OP_BEQZ) ? rd_f : rs_f;
                            addr2_d   = rt_f;
                            dest_d    = rd_f;
                            alu_op_d  = opcode;
                            src_imm_d = (opcode == OP_ADDI);
                            imm_d     = (opcode == OP_ADDI) ? {10'd0, rt_f} : 13'd0;
                        end
                    endcase
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_BEQZ) begin
                    state_d = S_FETCH;
                    pc_d    = (bus.i_dataA == 13'd0) ? branch_pc : pc_inc;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            dest_q    <= '0;
            alu_op_q  <= '0;
            src_imm_q <= 1'b0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            dest_q    <= dest_d;
            alu_op_q  <= alu_op_d;
            src_imm_q <= src_imm_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.o_pc        = pc_q;
    assign bus.o_instrReq  = (state_q == S_FETCH);
    assign bus.o_memRead   = (state_q == S_READ);
    assign bus.o_memWrite  = (state_q == S_WB);
    assign bus.o_address1  = addr1_q;
    assign bus.o_address2  = addr2_q;
    assign bus.o_destReg   = dest_q;
    assign bus.o_aluOp     = alu_op_q;
    assign bus.o_aluSrcImm = src_imm_q;
    assign bus.o_imm       = imm_q;
    assign bus.o_busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.o_halt      = (state_q == S_HALT);
    assign bus.o_illegal   = illegal_q;

    // HALT only leaves through reset, and the two register-file enables never overlap.
    a_rw_exclusive: assert property (@(posedge clk) !(bus.o_memRead && bus.o_memWrite));
    a_halt_terminal: assert property (@(posedge clk) disable iff (reset)
                                      (state_q == S_HALT) |=> (state_q == S_HALT));
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level schedule model is compared
// against every DUT output each cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam int PW = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    localparam int A_NONE = 0, A_INC = 1, A_JUMP = 2, A_BRANCH = 3, A_STOP = 4, A_STOP_ILL = 5;

    typedef struct {
        bit rd_en;
        bit wr_en;
        bit fields;
        int act;
    } cyc_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_controller_if #(.PC_WIDTH(PW)) bus();

    multicycle_controller #(.PC_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    cyc_t          sched[$];
    bit            m_ready = 1'b0;
    int            m_mode;
    logic [PW-1:0] m_pc;
    bit            m_ill;
    logic [12:0]   m_instr;
    logic [2:0]    m_a1, m_a2, m_dst;
    logic [3:0]    m_op;
    bit            m_src;
    logic [12:0]   m_imm;

    function automatic logic [12:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic bit illegal_instr(input logic [12:0] ins);
        bit rd7 = (ins[8:6] == 3'd7);
        bit rs7 = (ins[5:3] == 3'd7);
        bit rt7 = (ins[2:0] == 3'd7);
        case (ins[12:9])
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8: return rd7 || rs7 || rt7;
            4'd6, 4'd9, 4'd10:                        return rd7 || rs7;
            4'd11:                                    return rd7;
            4'd12, 4'd13:                             return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Turn one accepted instruction into the list of cycles it occupies after FETCH.
    task automatic expand(input logic [12:0] ins);
        cyc_t       c;
        logic [3:0] op = ins[12:9];
        bit         bad = illegal_instr(ins);
        c = '{1'b0, 1'b0, 1'b0, A_NONE};
        if (bad)               c.act = A_STOP_ILL;
        else if (op == 4'd0)   c.act = A_INC;
        else if (op == 4'd14)  c.act = A_JUMP;
        else if (op == 4'd15)  c.act = A_STOP;
        sched.push_back(c);
        if (!bad && op != 4'd0 && op != 4'd14 && op != 4'd15) begin
            sched.push_back('{1'b1, 1'b0, 1'b1, A_NONE});
            sched.push_back('{1'b0, 1'b0, 1'b0, (op == 4'd11) ? A_BRANCH : A_NONE});
            if (op != 4'd11) sched.push_back('{1'b0, 1'b1, 1'b0, A_INC});
        end
    endtask

    initial begin : model
        cyc_t c;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_ready = 1'b1;
                m_mode  = M_IDLE;
                m_pc    = '0;
                m_ill   = 1'b0;
                m_instr = '0;
                m_a1 = '0; m_a2 = '0; m_dst = '0; m_op = '0; m_src = 1'b0; m_imm = '0;
                sched.delete();
            end else if (m_ready) begin
                if (m_mode == M_IDLE) begin
                    if (bus.i_start) begin
                        m_mode = M_RUN;
                        m_pc   = '0;
                    end
                end else if (m_mode == M_RUN) begin
                    if (sched.size() == 0) begin
                        if (bus.i_instrValid) begin
                            m_instr = bus.i_instr;
                            expand(m_instr);
                        end
                    end else begin
                        c = sched.pop_front();
                        case (c.act)
                            A_INC:      m_pc = m_pc + 1'b1;
                            A_JUMP:     m_pc = m_instr[7:0];
                            A_BRANCH:   m_pc = (bus.i_dataA == 13'd0) ? {2'b00, m_instr[5:0]} : m_pc + 1'b1;
                            A_STOP:     m_mode = M_HALT;
                            A_STOP_ILL: begin m_mode = M_HALT; m_ill = 1'b1; end
                            default:    m_mode = M_RUN;
                        endcase
                    end
                end
                if (m_mode == M_RUN && sched.size() != 0 && sched[0].fields) begin
                    m_op  = m_instr[12:9];
                    m_a1  = (m_op == 4'd11) ? m_instr[8:6] : m_instr[5:3];
                    m_a2  = m_instr[2:0];
                    m_dst = m_instr[8:6];
                    m_src = (m_op == 4'd9);
                    m_imm = (m_op == 4'd9) ? {10'd0, m_instr[2:0]} : 13'd0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : compare
        bit e_run, e_rd, e_wr;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                e_run = (m_mode == M_RUN);
                e_rd  = e_run && sched.size() != 0 && sched[0].rd_en;
                e_wr  = e_run && sched.size() != 0 && sched[0].wr_en;
                checkOutput("pc",       32'(bus.o_pc),        32'(m_pc));
                checkOutput("instrReq", 32'(bus.o_instrReq),  32'(e_run && sched.size() == 0));
                checkOutput("memRead",  32'(bus.o_memRead),   32'(e_rd));
                checkOutput("memWrite", 32'(bus.o_memWrite),  32'(e_wr));
                checkOutput("address1", 32'(bus.o_address1),  32'(m_a1));
                checkOutput("address2", 32'(bus.o_address2),  32'(m_a2));
                checkOutput("destReg",  32'(bus.o_destReg),   32'(m_dst));
                checkOutput("aluOp",    32'(bus.o_aluOp),     32'(m_op));
                checkOutput("aluSrcImm",32'(bus.o_aluSrcImm), 32'(m_src));
                checkOutput("imm",      32'(bus.o_imm),       32'(m_imm));
                checkOutput("busy",     32'(bus.o_busy),      32'(e_run));
                checkOutput("halt",     32'(bus.o_halt),      32'(m_mode == M_HALT));
                checkOutput("illegal",  32'(bus.o_illegal),   32'(m_ill));
            end
        end
    end

    task automatic applyStimulus(input bit s, input logic [12:0] ins, input bit v, input logic [12:0] a);
        @(posedge clk);
        #2;
        bus.i_start      = s;
        bus.i_instr      = ins;
        bus.i_instrValid = v;
        bus.i_dataA      = a;
    endtask

    task automatic runInstr(input logic [12:0] ins, input logic [12:0] a, input int n);
        applyStimulus(1'b0, ins, 1'b1, a);
        repeat (n - 1) applyStimulus(1'b0, 13'd0, 1'b0, a);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        reset = 1'b0;
    endtask

    logic [12:0] alu_tab [0:8];
    logic [12:0] ill_tab [0:4];

    initial begin : stimulus
        reset = 1'b1;
        bus.i_start = 1'b0; bus.i_instr = '0; bus.i_instrValid = 1'b0; bus.i_dataA = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_pc", 32'(bus.o_pc), 0);
        checkOutput("rst_busy", 32'(bus.o_busy), 0);
        checkOutput("rst_instrReq", 32'(bus.o_instrReq), 0);
        checkOutput("rst_halt", 32'(bus.o_halt), 0);

        // ADD r3,r1,r2 valid on the first FETCH cycle
        applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'h02CA, 1'b1, 13'd0);
        @(negedge clk);
        checkOutput("add_c1_instrReq", 32'(bus.o_instrReq), 1);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("add_c3_memRead", 32'(bus.o_memRead), 1);
        checkOutput("add_c3_addr1", 32'(bus.o_address1), 1);
        checkOutput("add_c3_addr2", 32'(bus.o_address2), 2);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("add_c5_memWrite", 32'(bus.o_memWrite), 1);
        checkOutput("add_c5_destReg", 32'(bus.o_destReg), 3);
        checkOutput("add_c5_aluOp", 32'(bus.o_aluOp), 1);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("add_pc", 32'(bus.o_pc), 1);

        // BEQZ r2 -> 20, taken then not taken
        runInstr({4'b1011, 3'd2, 6'd20}, 13'd0, 4);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("beqz_taken_pc", 32'(bus.o_pc), 20);
        checkOutput("beqz_memWrite", 32'(bus.o_memWrite), 0);
        runInstr({4'b1011, 3'd2, 6'd20}, 13'd5, 4);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("beqz_not_taken_pc", 32'(bus.o_pc), 21);

        // Fetch wait of five cycles with a stray i_start, then ADDI r1,r2,#5
        repeat (5) begin
            applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
            @(negedge clk);
            checkOutput("wait_instrReq", 32'(bus.o_instrReq), 1);
            checkOutput("wait_pc", 32'(bus.o_pc), 21);
            checkOutput("wait_memRead", 32'(bus.o_memRead), 0);
        end
        applyStimulus(1'b0, enc(4'd9, 3'd1, 3'd2, 3'd5), 1'b1, 13'd0);
        repeat (2) applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("addi_srcImm", 32'(bus.o_aluSrcImm), 1);
        checkOutput("addi_imm", 32'(bus.o_imm), 5);
        checkOutput("addi_aluOp", 32'(bus.o_aluOp), 9);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("addi_pc", 32'(bus.o_pc), 22);

        // Remaining ALU forms; unused fields may legally hold 7
        alu_tab[0] = enc(4'd2, 3'd4, 3'd5, 3'd6);
        alu_tab[1] = enc(4'd3, 3'd0, 3'd1, 3'd2);
        alu_tab[2] = enc(4'd4, 3'd6, 3'd3, 3'd0);
        alu_tab[3] = enc(4'd5, 3'd2, 3'd4, 3'd6);
        alu_tab[4] = enc(4'd6, 3'd1, 3'd2, 3'd7);
        alu_tab[5] = enc(4'd7, 3'd5, 3'd6, 3'd1);
        alu_tab[6] = enc(4'd8, 3'd3, 3'd0, 3'd4);
        alu_tab[7] = enc(4'd10, 3'd6, 3'd0, 3'd7);
        alu_tab[8] = enc(4'd9, 3'd2, 3'd3, 3'd7);
        for (int i = 0; i < 9; i++) runInstr(alu_tab[i], 13'd0, 5);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("alu_loop_pc", 32'(bus.o_pc), 31);

        // JMP to 0xFF then NOP wraps; JMP ignores instr[8]
        runInstr({4'b1110, 1'b0, 8'hFF}, 13'd0, 2);
        applyStimulus(1'b0, 13'd0, 1'b1, 13'd0);
        @(negedge clk);
        checkOutput("jmp_pc", 32'(bus.o_pc), 255);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("wrap_pc", 32'(bus.o_pc), 0);
        runInstr({4'b1110, 1'b1, 8'h05}, 13'd0, 2);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("jmp_bit8_pc", 32'(bus.o_pc), 5);

        // Reset during WB, restart, then reset during a fetch wait
        runInstr(13'h02CA, 13'd0, 5);
        doReset();
        @(negedge clk);
        checkOutput("wbrst_memWrite", 32'(bus.o_memWrite), 0);
        checkOutput("wbrst_busy", 32'(bus.o_busy), 0);
        checkOutput("wbrst_pc", 32'(bus.o_pc), 0);
        checkOutput("wbrst_destReg", 32'(bus.o_destReg), 0);
        checkOutput("wbrst_aluOp", 32'(bus.o_aluOp), 0);
        applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("restart_instrReq", 32'(bus.o_instrReq), 1);
        checkOutput("restart_pc", 32'(bus.o_pc), 0);
        doReset();
        @(negedge clk);
        checkOutput("fetchrst_instrReq", 32'(bus.o_instrReq), 0);

        // Illegal encodings halt with o_illegal; i_start afterwards is ignored
        ill_tab[0] = enc(4'd12, 3'd0, 3'd0, 3'd0);
        ill_tab[1] = enc(4'd1, 3'd7, 3'd1, 3'd2);
        ill_tab[2] = enc(4'd2, 3'd1, 3'd2, 3'd7);
        ill_tab[3] = enc(4'd6, 3'd1, 3'd7, 3'd0);
        ill_tab[4] = {4'b1011, 3'd7, 6'd3};
        for (int i = 0; i < 5; i++) begin
            doReset();
            applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
            runInstr(ill_tab[i], 13'd0, 2);
            repeat (3) applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
            @(negedge clk);
            checkOutput("ill_halt", 32'(bus.o_halt), 1);
            checkOutput("ill_flag", 32'(bus.o_illegal), 1);
            checkOutput("ill_busy", 32'(bus.o_busy), 0);
            checkOutput("ill_instrReq", 32'(bus.o_instrReq), 0);
        end

        // HALT opcode stops without flagging illegal
        doReset();
        applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
        runInstr(enc(4'd15, 3'd0, 3'd0, 3'd0), 13'd0, 2);
        applyStimulus(1'b1, 13'd0, 1'b0, 13'd0);
        @(negedge clk);
        checkOutput("halt_halt", 32'(bus.o_halt), 1);
        checkOutput("halt_illegal", 32'(bus.o_illegal), 0);
        applyStimulus(1'b0, 13'd0, 1'b0, 13'd0);

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
